// File: rtl/latch_tx_pkg.sv
// ---------------------------------------------------------------------------
// latch_tx_pkg
//
// Shared definitions for the latch-targeted PISO transmitter:
//   - state_t        : FSM state encoding (IDLE / SHIFT / DONE)
//   - MIN_WIDTH      : smallest legal frame width
//   - MIN_BIT_CYCLES : smallest legal clocks-per-bit; one cycle with the latch
//                      open and one with it closed on stable data
//   - params_ok()    : parameter legality check used at elaboration time
// ---------------------------------------------------------------------------
package latch_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int MIN_WIDTH      = 2;
  localparam int MIN_BIT_CYCLES = 2;

  function automatic bit params_ok(input int width, input int bit_cycles);
    return (width >= MIN_WIDTH) && (bit_cycles >= MIN_BIT_CYCLES);
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// ---------------------------------------------------------------------------
// piso_shreg
//
// WIDTH-bit loadable shift register feeding the serial transmitter.
//
// Parameters:
//   WIDTH     : register width (>= 2)
//   LSB_FIRST : 1 shifts right and presents bit 0, 0 shifts left and
//               presents bit WIDTH-1
//
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears the register
//   load  : capture din on the next edge (wins over shift)
//   shift : advance one bit toward the output on the next edge
//   din   : parallel word to load
//   dout  : bit currently presented at the output end
//   dnext : bit that will be presented after the next edge, given the
//           current load/shift request
// ---------------------------------------------------------------------------
module piso_shreg
  import latch_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout,
  output logic             dnext
);

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_n;

  // Next register contents; load has priority so a back-to-back frame
  // can start on the same edge the previous one finishes.
  always_comb begin
    data_n = data;
    if (load) begin
      data_n = din;
    end else if (shift) begin
      if (LSB_FIRST) begin
        data_n = {1'b0, data[WIDTH-1:1]};
      end else begin
        data_n = {data[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else begin
      data <= data_n;
    end
  end

  // The top registers dnext into sd, so the serial output lines up with
  // the register contents without an extra cycle of latency.
  assign dout  = LSB_FIRST ? data[0]   : data[WIDTH-1];
  assign dnext = LSB_FIRST ? data_n[0] : data_n[WIDTH-1];

endmodule

// File: rtl/latch_piso_tx.sv
// ---------------------------------------------------------------------------
// latch_piso_tx
//
// Parallel-in, serial-out transmitter driving a data/enable pair into an
// enable-gated D-latch. Each bit is held on sd for BIT_CYCLES clocks; sen is
// high for all but the last of those clocks, so the latch closes while sd is
// still stable.
//
// Parameters:
//   WIDTH      : frame width in bits (>= 2)
//   BIT_CYCLES : clocks per bit (>= 2)
//   LSB_FIRST  : 1 sends din[0] first, 0 sends din[WIDTH-1] first
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   load : start-of-frame request, accepted in IDLE and DONE
//   din  : parallel word captured when load is accepted
//   sd   : serial data (registered)
//   sen  : serial enable / latch strobe (registered)
//   busy : high while a frame is being shifted out (registered)
//   done : one-cycle pulse after the last bit (registered)
// ---------------------------------------------------------------------------
module latch_piso_tx
  import latch_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 2,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             sd,
  output logic             sen,
  output logic             busy,
  output logic             done
);

  if (!params_ok(WIDTH, BIT_CYCLES)) begin : g_bad_params
    $error("latch_piso_tx: WIDTH and BIT_CYCLES must both be at least 2");
  end

  localparam int BW = $clog2(WIDTH);
  localparam int PW = $clog2(BIT_CYCLES);

  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(BIT_CYCLES - 1);

  state_t        state;
  state_t        state_n;
  logic [BW-1:0] bitcnt;
  logic [BW-1:0] bitcnt_n;
  logic [PW-1:0] phase;
  logic [PW-1:0] phase_n;

  logic sh_load;
  logic sh_shift;
  logic sh_dout;
  logic sh_dnext;

  logic sd_n;
  logic sen_n;
  logic busy_n;
  logic done_n;

  piso_shreg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (din),
    .dout  (sh_dout),
    .dnext (sh_dnext)
  );

  // State, counter and pipeline registers. Reset clears everything at once,
  // which drops any partial frame without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      bitcnt <= '0;
      phase  <= '0;
      sd     <= 1'b0;
      sen    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      bitcnt <= bitcnt_n;
      phase  <= phase_n;
      sd     <= sd_n;
      sen    <= sen_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  // Next-state and counter logic. Loads are only honoured in IDLE and DONE,
  // so load/din activity during SHIFT cannot disturb a frame in flight.
  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    phase_n  = phase;
    sh_load  = 1'b0;
    sh_shift = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (load) begin
          sh_load  = 1'b1;
          bitcnt_n = '0;
          phase_n  = '0;
          state_n  = ST_SHIFT;
        end else begin
          state_n  = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (phase == PHASE_LAST) begin
          phase_n  = '0;
          sh_shift = 1'b1;
          if (bitcnt == BIT_LAST) begin
            bitcnt_n = '0;
            state_n  = ST_DONE;
          end else begin
            bitcnt_n = bitcnt + BW'(1);
          end
        end else begin
          phase_n = phase + PW'(1);
        end
      end

      default: begin
        state_n  = ST_IDLE;
        bitcnt_n = '0;
        phase_n  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear in the same
  // cycle as the state they describe, with no input-to-output path.
  // sen drops on the final phase of each bit while sd is held.
  always_comb begin
    sd_n   = 1'b0;
    sen_n  = 1'b0;
    busy_n = 1'b0;
    done_n = 1'b0;

    if (state_n == ST_SHIFT) begin
      busy_n = 1'b1;
      sen_n  = (phase_n != PHASE_LAST);
      sd_n   = (sh_load || sh_shift) ? sh_dnext : sh_dout;
    end

    if (state_n == ST_DONE) begin
      done_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_latch_piso_tx.sv
// ---------------------------------------------------------------------------
// tb_latch_piso_tx
//
// Directed bench for latch_piso_tx. Three instances share clock and reset:
//   u_a : WIDTH 8, BIT_CYCLES 2, LSB first
//   u_m : WIDTH 8, BIT_CYCLES 2, MSB first
//   u_s : WIDTH 8, BIT_CYCLES 4, LSB first
// Expected serial sequences are written out by hand as "seq", where seq[k]
// is the k-th bit transmitted. Outputs are sampled 1 time unit after edges.
// ---------------------------------------------------------------------------
module tb_latch_piso_tx;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       load_a, load_m, load_s;
  logic [7:0] din_a, din_m, din_s;
  logic       sd_a, sen_a, busy_a, done_a;
  logic       sd_m, sen_m, busy_m, done_m;
  logic       sd_s, sen_s, busy_s, done_s;

  // Behavioural D-latches standing in for the receiving capture stage.
  logic latch_a;
  logic latch_s;

  always_latch begin
    if (sen_a) latch_a <= sd_a;
  end

  always_latch begin
    if (sen_s) latch_s <= sd_s;
  end

  latch_piso_tx #(.WIDTH(8), .BIT_CYCLES(2), .LSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .load(load_a), .din(din_a),
    .sd(sd_a), .sen(sen_a), .busy(busy_a), .done(done_a)
  );

  latch_piso_tx #(.WIDTH(8), .BIT_CYCLES(2), .LSB_FIRST(1'b0)) u_m (
    .clk(clk), .rst(rst), .load(load_m), .din(din_m),
    .sd(sd_m), .sen(sen_m), .busy(busy_m), .done(done_m)
  );

  latch_piso_tx #(.WIDTH(8), .BIT_CYCLES(4), .LSB_FIRST(1'b1)) u_s (
    .clk(clk), .rst(rst), .load(load_s), .din(din_s),
    .sd(sd_s), .sen(sen_s), .busy(busy_s), .done(done_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset values on all three instances, during and after reset.
  task automatic test_reset();
    rst = 1'b1;
    load_a = 1'b0; load_m = 1'b0; load_s = 1'b0;
    din_a = 8'h00; din_m = 8'h00; din_s = 8'h00;
    #2;
    checks++;
    if ({sd_a, sen_a, busy_a, done_a} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_a got %b expected 0000", {sd_a, sen_a, busy_a, done_a});
    end
    checks++;
    if ({sd_m, sen_m, busy_m, done_m} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_m got %b expected 0000", {sd_m, sen_m, busy_m, done_m});
    end
    checks++;
    if ({sd_s, sen_s, busy_s, done_s} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_s got %b expected 0000", {sd_s, sen_s, busy_s, done_s});
    end
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({sd_a, sen_a, busy_a, done_a} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL idle_a got %b expected 0000", {sd_a, sen_a, busy_a, done_a});
    end
  endtask

  // 8'hA5 LSB first: 1,0,1,0,0,1,0,1 with sen 1,0 per bit, done at cycle 17.
  task automatic test_basic();
    logic [7:0] seq;
    logic [3:0] exp;
    seq = 8'hA5;
    $display("[TB] basic frame 8'hA5 LSB first");
    din_a = 8'hA5; load_a = 1'b1;
    tick();
    load_a = 1'b0; din_a = 8'h00;
    for (int c = 1; c <= 18; c++) begin
      exp[1] = (c <= 16);
      exp[2] = exp[1] && (((c - 1) % 2) != 1);
      exp[3] = exp[1] ? seq[(c - 1) / 2] : 1'b0;
      exp[0] = (c == 17);
      checks++;
      if ({sd_a, sen_a, busy_a, done_a} !== exp) begin
        errors++;
        $display("[TB] FAIL basic c=%0d {sd,sen,busy,done} got %b expected %b",
                 c, {sd_a, sen_a, busy_a, done_a}, exp);
      end
      if (exp[1] && !exp[2]) begin
        checks++;
        if (latch_a !== seq[(c - 1) / 2]) begin
          errors++;
          $display("[TB] FAIL basic_latch c=%0d got %b expected %b",
                   c, latch_a, seq[(c - 1) / 2]);
        end
      end
      tick();
    end
  endtask

  // MSB first: 8'hA5 sends bits 7..0 (seq 8'hA5), 8'h01 sends seq 8'h80.
  task automatic test_msb_first();
    logic [7:0] words [2];
    logic [7:0] seqs  [2];
    logic [3:0] exp;
    words[0] = 8'hA5; seqs[0] = 8'hA5;
    words[1] = 8'h01; seqs[1] = 8'h80;
    $display("[TB] MSB-first frames");
    for (int f = 0; f < 2; f++) begin
      din_m = words[f]; load_m = 1'b1;
      tick();
      load_m = 1'b0; din_m = 8'h00;
      for (int c = 1; c <= 18; c++) begin
        exp[1] = (c <= 16);
        exp[2] = exp[1] && (((c - 1) % 2) != 1);
        exp[3] = exp[1] ? seqs[f][(c - 1) / 2] : 1'b0;
        exp[0] = (c == 17);
        checks++;
        if ({sd_m, sen_m, busy_m, done_m} !== exp) begin
          errors++;
          $display("[TB] FAIL msb_first f=%0d c=%0d got %b expected %b",
                   f, c, {sd_m, sen_m, busy_m, done_m}, exp);
        end
        tick();
      end
    end
  endtask

  // A load of 8'hFF at cycle 5 of an 8'h00 frame must be ignored.
  task automatic test_load_while_busy();
    logic [3:0] exp;
    $display("[TB] load while busy");
    din_a = 8'h00; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      if (c == 6) begin
        load_a = 1'b0; din_a = 8'h00;
      end
      exp[1] = (c <= 16);
      exp[2] = exp[1] && (((c - 1) % 2) != 1);
      exp[3] = 1'b0;
      exp[0] = (c == 17);
      checks++;
      if ({sd_a, sen_a, busy_a, done_a} !== exp) begin
        errors++;
        $display("[TB] FAIL load_busy c=%0d got %b expected %b",
                 c, {sd_a, sen_a, busy_a, done_a}, exp);
      end
      if (c == 5) begin
        load_a = 1'b1; din_a = 8'hFF;
      end
      tick();
    end
  endtask

  // Load in the done cycle: second frame (8'h3C) starts the very next cycle.
  task automatic test_back_to_back();
    logic [7:0] seq1;
    logic [7:0] seq2;
    logic [3:0] exp;
    seq1 = 8'hA5;
    seq2 = 8'h3C;
    $display("[TB] back-to-back frames");
    din_a = 8'hA5; load_a = 1'b1;
    tick();
    load_a = 1'b0; din_a = 8'h00;
    for (int c = 1; c <= 17; c++) begin
      exp[1] = (c <= 16);
      exp[2] = exp[1] && (((c - 1) % 2) != 1);
      exp[3] = exp[1] ? seq1[(c - 1) / 2] : 1'b0;
      exp[0] = (c == 17);
      checks++;
      if ({sd_a, sen_a, busy_a, done_a} !== exp) begin
        errors++;
        $display("[TB] FAIL b2b_first c=%0d got %b expected %b",
                 c, {sd_a, sen_a, busy_a, done_a}, exp);
      end
      if (c == 17) begin
        load_a = 1'b1; din_a = 8'h3C;
      end
      tick();
    end
    load_a = 1'b0; din_a = 8'h00;
    for (int c = 1; c <= 18; c++) begin
      exp[1] = (c <= 16);
      exp[2] = exp[1] && (((c - 1) % 2) != 1);
      exp[3] = exp[1] ? seq2[(c - 1) / 2] : 1'b0;
      exp[0] = (c == 17);
      checks++;
      if ({sd_a, sen_a, busy_a, done_a} !== exp) begin
        errors++;
        $display("[TB] FAIL b2b_second c=%0d got %b expected %b",
                 c, {sd_a, sen_a, busy_a, done_a}, exp);
      end
      tick();
    end
  endtask

  // Reset at cycle 7 of an 8'hFF frame clears outputs before the next edge,
  // no done follows, and a fresh 8'h0D frame (seq 1,0,1,1,0,0,0,0) works.
  task automatic test_reset_mid_frame();
    logic [7:0] seq;
    logic [3:0] exp;
    seq = 8'h0D;
    $display("[TB] reset mid-frame");
    din_a = 8'hFF; load_a = 1'b1;
    tick();
    load_a = 1'b0; din_a = 8'h00;
    for (int c = 1; c <= 7; c++) begin
      exp = {1'b1, (((c - 1) % 2) != 1), 1'b1, 1'b0};
      checks++;
      if ({sd_a, sen_a, busy_a, done_a} !== exp) begin
        errors++;
        $display("[TB] FAIL pre_reset c=%0d got %b expected %b",
                 c, {sd_a, sen_a, busy_a, done_a}, exp);
      end
      if (c < 7) tick();
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({sd_a, sen_a, busy_a, done_a} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL async_reset got %b expected 0000", {sd_a, sen_a, busy_a, done_a});
    end
    rst = 1'b0;
    tick();
    for (int c = 0; c < 20; c++) begin
      checks++;
      if ({sd_a, sen_a, busy_a, done_a} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL post_reset c=%0d got %b expected 0000",
                 c, {sd_a, sen_a, busy_a, done_a});
      end
      tick();
    end
    din_a = 8'h0D; load_a = 1'b1;
    tick();
    load_a = 1'b0; din_a = 8'h00;
    for (int c = 1; c <= 18; c++) begin
      exp[1] = (c <= 16);
      exp[2] = exp[1] && (((c - 1) % 2) != 1);
      exp[3] = exp[1] ? seq[(c - 1) / 2] : 1'b0;
      exp[0] = (c == 17);
      checks++;
      if ({sd_a, sen_a, busy_a, done_a} !== exp) begin
        errors++;
        $display("[TB] FAIL reload c=%0d got %b expected %b",
                 c, {sd_a, sen_a, busy_a, done_a}, exp);
      end
      tick();
    end
  endtask

  // BIT_CYCLES 4, 8'h81: sen 1,1,1,0 per bit, done at cycle 33.
  task automatic test_stretched_bits();
    logic [7:0] seq;
    logic [3:0] exp;
    seq = 8'h81;
    $display("[TB] stretched bits");
    din_s = 8'h81; load_s = 1'b1;
    tick();
    load_s = 1'b0; din_s = 8'h00;
    for (int c = 1; c <= 34; c++) begin
      exp[1] = (c <= 32);
      exp[2] = exp[1] && (((c - 1) % 4) != 3);
      exp[3] = exp[1] ? seq[(c - 1) / 4] : 1'b0;
      exp[0] = (c == 33);
      checks++;
      if ({sd_s, sen_s, busy_s, done_s} !== exp) begin
        errors++;
        $display("[TB] FAIL stretched c=%0d got %b expected %b",
                 c, {sd_s, sen_s, busy_s, done_s}, exp);
      end
      if (exp[1] && !exp[2]) begin
        checks++;
        if (latch_s !== seq[(c - 1) / 4]) begin
          errors++;
          $display("[TB] FAIL stretched_latch c=%0d got %b expected %b",
                   c, latch_s, seq[(c - 1) / 4]);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_msb_first();
    test_load_while_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_stretched_bits();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/latch_piso_tx.md
# latch_piso_tx

Parallel-in, serial-out transmitter that drives a data/enable pair toward an enable-gated D-latch capture stage. A parallel word is loaded and then presented one bit at a time on `sd`, with the strobe `sen` framing each bit. During each bit, the latch is transparent while `sen` is high and closes while `sd` is still stable. The block sits on the sending side of the latch-based capture path and provides a simple load/busy/done handshake to its upstream controller.

## Interface
- `WIDTH`, default 8: frame width in bits; must be ≥ 2.
- `BIT_CYCLES`, default 2: clocks per bit; must be ≥ 2.
- `LSB_FIRST`, default 1: 1 sends `din[0]` first; 0 sends `din[WIDTH-1]` first.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `load` input, 1 bit: request to start a frame; sampled on the rising edge.
- `din` input, `WIDTH` bits: word captured when `load` is accepted.
- `sd` output, 1 bit: serial data, registered.
- `sen` output, 1 bit: serial enable/strobe, registered.
- `busy` output, 1 bit: a frame is in progress.
- `done` output, 1 bit: one-cycle pulse after the last bit.

## Operation
- **Reset values:** `sd`=0, `sen`=0, `busy`=0, `done`=0, state `IDLE`, all counters 0.
- **States:** `IDLE`, `SHIFT`, `DONE`.
- **IDLE**
  - `load`=1 captures `din` into the shift register, clears the counters and moves to `SHIFT`.
  - `load`=0 keeps the state; `sd` and `sen` are held at 0.
- **SHIFT**
  - `sd` = current bit of the shift register.
  - Phase counter runs 0..`BIT_CYCLES`-1.
  - `sen`=1 for phases 0..`BIT_CYCLES`-2 and `sen`=0 on the last phase. `sd` is unchanged across all phases of a bit, so the latch closes on stable data.
  - On the last phase, the register shifts (right if `LSB_FIRST`, else left) and the bit counter increments.
  - After the last phase of bit `WIDTH`-1, go to `DONE`.
- **DONE:** lasts one cycle.
  - `done`=1, `busy`=0, `sd`=0, `sen`=0.
  - `load`=1 in this cycle is accepted; the next cycle is `SHIFT` with the new word (back-to-back frames).
  - Otherwise go to `IDLE`.
- **busy** = 1 exactly while in `SHIFT`.
- **load while busy:** ignored. `din` changes while busy have no effect.
- **Reset mid-frame:** takes effect immediately (asynchronously). All outputs go to their reset values and the partial frame is discarded; no `done` pulse.
- **Counter widths:** bit counter is `$clog2(WIDTH)` bits, phase counter is `$clog2(BIT_CYCLES)` bits. Compare against `WIDTH`-1 and `BIT_CYCLES`-1; no reliance on wrap-around.

## Timing
- Cycle 0: `load` accepted at the edge.
- Bit k (k = 0..`WIDTH`-1) occupies cycles 1+k·`BIT_CYCLES` through (k+1)·`BIT_CYCLES`.
- `sen` falls on the last cycle of each bit.
- `done` is high in cycle `WIDTH`·`BIT_CYCLES`+1; `busy` is low in that same cycle.
- Frame latency from load to `done` is `WIDTH`·`BIT_CYCLES`+1 cycles.
- Back-to-back throughput is one frame per `WIDTH`·`BIT_CYCLES`+1 cycles.
- No combinational path from any input to any output.

## Structure
- Shared package `latch_tx_pkg`:
  - state encoding constants `ST_IDLE`=2'd0, `ST_SHIFT`=2'd1, `ST_DONE`=2'd2;
  - the `BIT_CYCLES` ≥ 2 and `WIDTH` ≥ 2 limits, checked by an elaboration-time assertion.
- One sub-module, `piso_shreg`: `WIDTH`-bit loadable shift register with `load`, `shift` and `LSB_FIRST` direction, exposing the current output bit.
- The FSM, counters and output registers live in the top module.

## Test plan
- **Basic frame:** `WIDTH`=8, `BIT_CYCLES`=2, `LSB_FIRST`=1, `din`=8'hA5, `load` pulse at cycle 0.
  - `sd` = 1,0,1,0,0,1,0,1, each bit held 2 cycles.
  - `sen` = 1,0 per bit.
  - `busy` high for cycles 1–16; `done` high at cycle 17 only.
  - A D-latch model driven by `sd`/`sen` holds each expected bit after every `sen` fall.
- **MSB first:** `LSB_FIRST`=0, `din`=8'hA5 → `sd` = 1,0,1,0,0,1,0,1 in MSB-first order, i.e. bits 7 down to 0. Repeat with 8'h01 → `sd`=1 only in the final bit.
- **Load while busy:** `load` with `din`=8'hFF at cycle 5 of a frame for 8'h00 → `sd` stays 0 for the whole frame; `done` at cycle 17; no second frame starts.
- **Back-to-back:** `load` asserted in the `done` cycle with 8'h3C → the second frame's first bit appears the next cycle; `done` is low between the frames.
- **Reset mid-frame:** `rst` pulsed at cycle 7 → `sd`, `sen`, `busy`, `done` all go to 0 before the next edge; no `done` pulse. A new `load` afterwards transmits correctly.
- **Stretched bits:** `BIT_CYCLES`=4, `din`=8'h81 → `sen` pattern per bit is 1,1,1,0; `done` at cycle 33.
